// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding and hazard controller beside EXE: forwarding selects,
// load-use stall/bubble, memory freeze, memory-wait watchdog and stall counter.
// Define FWD_HAZARD_FORWARDING_EN to enable forwarding. Without it, fwd_sel is
// held at 0 and every RAW dependency on a not-yet-written value stalls.
module fwd_hazard_ctrl #(
  parameter int REG_AW    = 4,
  parameter int NUM_SRC   = 3,
  parameter int FWD_DEPTH = 2,
  parameter int WAIT_MAX  = 64,
  localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   exe_src,
  input  logic [NUM_SRC-1:0]          exe_src_vld,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_vld,
  input  logic                        exe_wb_en,
  input  logic                        exe_mem_r_en,
  input  logic [REG_AW-1:0]           exe_dest,
  input  logic [FWD_DEPTH-1:0]        stg_wb_en,
  input  logic [FWD_DEPTH*REG_AW-1:0] stg_dest,
  input  logic                        flush,
  input  logic                        mem_req,
  input  logic                        mem_ready,
  output logic [NUM_SRC*SELW-1:0]     fwd_sel,
  output logic                        stall_if_id,
  output logic                        bubble_id_exe,
  output logic                        freeze,
  output logic                        mem_timeout,
  output logic [15:0]                 stall_cnt
);

  // state  | meaning
  // S_RUN  | memory idle or completing this cycle
  // S_WAIT | pipeline frozen on an outstanding data-memory access
  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  localparam int CNTW = $clog2(WAIT_MAX + 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic            hazard;
  logic            lu;

  always_comb begin
    fwd_sel = '0;
    hazard  = 1'b0;
`ifdef FWD_HAZARD_FORWARDING_EN
    // Scan from WB toward MEM so the nearest matching stage overrides.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exe_src_vld[i]) begin
        for (int k = FWD_DEPTH; k >= 1; k--) begin
          if (stg_wb_en[k-1] && (stg_dest[(k-1)*REG_AW +: REG_AW] == exe_src[i*REG_AW +: REG_AW]))
            fwd_sel[i*SELW +: SELW] = SELW'(k);
        end
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_vld[i] && (id_src[i*REG_AW +: REG_AW] == exe_dest))
        hazard = hazard | (exe_mem_r_en & exe_wb_en);
    end
`else
    // WB is left out: the register file writes before it reads.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_vld[i]) begin
        if (exe_wb_en && (id_src[i*REG_AW +: REG_AW] == exe_dest))
          hazard = 1'b1;
        for (int k = 1; k < FWD_DEPTH; k++) begin
          if (stg_wb_en[k-1] && (stg_dest[(k-1)*REG_AW +: REG_AW] == id_src[i*REG_AW +: REG_AW]))
            hazard = 1'b1;
        end
      end
    end
`endif
  end

`ifndef FWD_HAZARD_FORWARDING_EN
  logic unused_sigs;
  assign unused_sigs = ^{exe_src, exe_src_vld, exe_mem_r_en, stg_dest, stg_wb_en};
`endif

  assign lu            = hazard & ~flush;
  assign freeze        = mem_req & ~mem_ready;
  assign stall_if_id   = freeze | lu;
  assign bubble_id_exe = ~freeze & lu;

  // wait_cnt counts consecutive frozen cycles, including the one spent in RUN.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    case (state_q)
      S_RUN: begin
        wait_cnt_d = freeze ? CNTW'(1) : '0;
        if (freeze) begin
          state_d = S_WAIT;
          if (WAIT_MAX == 1) mem_timeout_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != CNTW'(WAIT_MAX)) wait_cnt_d = wait_cnt_q + CNTW'(1);
        if (freeze && (wait_cnt_q == CNTW'(WAIT_MAX - 1))) mem_timeout_d = 1'b1;
        if (!freeze) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (stall_if_id && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a vector table for the combinational paths
// plus sequences for stall counting, memory freeze, watchdog and reset.
module tb_fwd_hazard_ctrl;
  localparam int REG_AW = 4, NUM_SRC = 3, FWD_DEPTH = 2, WAIT_MAX = 8;
`ifdef FWD_HAZARD_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] exe_src, id_src;
  logic [2:0]  exe_src_vld, id_src_vld;
  logic        exe_wb_en, exe_mem_r_en, flush, mem_req, mem_ready;
  logic [3:0]  exe_dest;
  logic [1:0]  stg_wb_en;
  logic [7:0]  stg_dest;
  logic [5:0]  fwd_sel;
  logic        stall_if_id, bubble_id_exe, freeze, mem_timeout;
  logic [15:0] stall_cnt;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .exe_src(exe_src), .exe_src_vld(exe_src_vld),
    .id_src(id_src), .id_src_vld(id_src_vld), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .stg_wb_en(stg_wb_en),
    .stg_dest(stg_dest), .flush(flush), .mem_req(mem_req), .mem_ready(mem_ready),
    .fwd_sel(fwd_sel), .stall_if_id(stall_if_id), .bubble_id_exe(bubble_id_exe),
    .freeze(freeze), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] exe_src;  logic [2:0] exe_vld;
    logic [11:0] id_src;   logic [2:0] id_vld;
    logic        wb;       logic       ld;      logic [3:0] dest;
    logic [1:0]  stg_wb;   logic [7:0] stg_dest;
    logic        flush;    logic       req;     logic       rdy;
    logic [5:0]  exp_fwd;
    logic        s_on, b_on, s_off, b_off, frz;
  } vec_t;

  vec_t vecs[15];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  function automatic vec_t mkv(input logic [11:0] es, input logic [2:0] ev, input logic [11:0] is,
                               input logic [2:0] iv, input logic wb, input logic ld, input logic [3:0] d,
                               input logic [1:0] sw, input logic [7:0] sd, input logic fl, input logic rq,
                               input logic rd, input logic [5:0] ef, input logic son, input logic bon,
                               input logic soff, input logic boff, input logic fz);
    vec_t v;
    v.exe_src = es; v.exe_vld = ev; v.id_src = is; v.id_vld = iv;
    v.wb = wb; v.ld = ld; v.dest = d; v.stg_wb = sw; v.stg_dest = sd;
    v.flush = fl; v.req = rq; v.rdy = rd; v.exp_fwd = ef;
    v.s_on = son; v.b_on = bon; v.s_off = soff; v.b_off = boff; v.frz = fz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exe_src = v.exe_src; exe_src_vld = v.exe_vld; id_src = v.id_src; id_src_vld = v.id_vld;
    exe_wb_en = v.wb; exe_mem_r_en = v.ld; exe_dest = v.dest;
    stg_wb_en = v.stg_wb; stg_dest = v.stg_dest; flush = v.flush;
    mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic clear_in();
    exe_src = '0; exe_src_vld = '0; id_src = '0; id_src_vld = '0;
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = '0;
    stg_wb_en = '0; stg_dest = '0; flush = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mkv({4'd0,4'd0,4'd3}, 3'b001, 12'h0, 3'b000, 0,0,4'd0, 2'b11, {4'd3,4'd3}, 0,0,0, 6'b000001, 0,0,0,0,0);
    vecs[1]  = mkv({4'd0,4'd0,4'd3}, 3'b001, 12'h0, 3'b000, 0,0,4'd0, 2'b10, {4'd3,4'd3}, 0,0,0, 6'b000010, 0,0,0,0,0);
    vecs[2]  = mkv({4'd0,4'd0,4'd3}, 3'b000, 12'h0, 3'b000, 0,0,4'd0, 2'b11, {4'd3,4'd3}, 0,0,0, 6'b000000, 0,0,0,0,0);
    vecs[3]  = mkv({4'd7,4'd5,4'd3}, 3'b111, 12'h0, 3'b000, 0,0,4'd0, 2'b11, {4'd7,4'd5}, 0,0,0, 6'b100100, 0,0,0,0,0);
    vecs[4]  = mkv(12'h0, 3'b000, {4'd0,4'd5,4'd0}, 3'b010, 1,1,4'd5, 2'b00, 8'h0, 0,0,0, 6'b0, 1,1,1,1,0);
    vecs[5]  = mkv(12'h0, 3'b000, {4'd0,4'd5,4'd0}, 3'b010, 1,1,4'd5, 2'b00, 8'h0, 1,0,0, 6'b0, 0,0,0,0,0);
    vecs[6]  = mkv(12'h0, 3'b000, {4'd0,4'd5,4'd0}, 3'b010, 1,0,4'd5, 2'b00, 8'h0, 0,0,0, 6'b0, 0,0,1,1,0);
    vecs[7]  = mkv({4'd0,4'd0,4'd2}, 3'b001, {4'd0,4'd0,4'd2}, 3'b001, 0,0,4'd0, 2'b01, {4'd0,4'd2}, 0,0,0, 6'b000001, 0,0,1,1,0);
    vecs[8]  = mkv({4'd0,4'd0,4'd2}, 3'b001, {4'd0,4'd0,4'd2}, 3'b001, 0,0,4'd0, 2'b10, {4'd2,4'd0}, 0,0,0, 6'b000010, 0,0,0,0,0);
    vecs[9]  = mkv(12'h0, 3'b000, {4'd0,4'd5,4'd4}, 3'b001, 1,1,4'd5, 2'b00, 8'h0, 0,0,0, 6'b0, 0,0,0,0,0);
    vecs[10] = mkv(12'h0, 3'b000, {4'd0,4'd5,4'd0}, 3'b010, 1,1,4'd5, 2'b00, 8'h0, 0,1,1, 6'b0, 1,1,1,1,0);
    vecs[11] = mkv(12'h0, 3'b000, {4'd0,4'd5,4'd0}, 3'b010, 1,1,4'd5, 2'b00, 8'h0, 0,1,0, 6'b0, 1,0,1,0,1);
    vecs[12] = mkv(12'h0, 3'b000, 12'h0, 3'b000, 0,0,4'd0, 2'b00, 8'h0, 0,0,0, 6'b0, 0,0,0,0,0);
    vecs[13] = mkv(12'h0, 3'b000, {4'd9,4'd0,4'd0}, 3'b100, 1,1,4'd9, 2'b00, 8'h0, 0,0,0, 6'b0, 1,1,1,1,0);
    vecs[14] = mkv(12'h0, 3'b000, {4'd0,4'd0,4'd9}, 3'b001, 0,1,4'd9, 2'b00, 8'h0, 0,0,0, 6'b0, 0,0,0,0,0);

    // Reset: registered outputs cleared, combinational outputs still live.
    clear_in();
    rst_n = 1'b0;
    #2;
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst mem_timeout", mem_timeout, 0);
    chk("rst freeze", freeze, 0);
    drive(vecs[4]);
    #1;
    chk("rst comb stall", stall_if_id, 1);
    clear_in();
    #1;
    chk("rst idle stall", stall_if_id, 0);
    #8 rst_n = 1'b1;

    // Single load-use stall, then the bubble clears the load in EXE.
    step();
    drive(vecs[4]);
    #1;
    chk("lu stall", stall_if_id, 1);
    chk("lu bubble", bubble_id_exe, 1);
    step();
    chk("lu stall_cnt 1", stall_cnt, 1);
    clear_in();
    #1;
    chk("lu after bubble", stall_if_id, 0);
    step();
    chk("lu stall_cnt hold", stall_cnt, 1);
    exp_cnt = 1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d fwd_sel", i), fwd_sel, FWD_ON ? vecs[i].exp_fwd : 6'b0);
      chk($sformatf("v%0d stall", i), stall_if_id, FWD_ON ? vecs[i].s_on : vecs[i].s_off);
      chk($sformatf("v%0d bubble", i), bubble_id_exe, FWD_ON ? vecs[i].b_on : vecs[i].b_off);
      chk($sformatf("v%0d freeze", i), freeze, vecs[i].frz);
      step();
      exp_cnt += int'(FWD_ON ? vecs[i].s_on : vecs[i].s_off);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, exp_cnt);
    end
    chk("table mem_timeout", mem_timeout, 0);

    // Freeze over a load-use: freeze wins, then one lu bubble after release.
    drive(vecs[11]);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("mw%0d freeze", c), freeze, 1);
      chk($sformatf("mw%0d stall", c), stall_if_id, 1);
      chk($sformatf("mw%0d bubble", c), bubble_id_exe, 0);
      step();
      exp_cnt++;
    end
    mem_ready = 1'b1;
    #1;
    chk("mw release freeze", freeze, 0);
    chk("mw release stall", stall_if_id, 1);
    chk("mw release bubble", bubble_id_exe, 1);
    step();
    exp_cnt++;
    clear_in();
    #1;
    chk("mw post bubble stall", stall_if_id, 0);
    chk("mw stall_cnt", stall_cnt, exp_cnt);
    chk("mw no timeout", mem_timeout, 0);
    step();

    // Watchdog: 10 frozen cycles, trips on the 8th edge, sticky after release.
    mem_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_cnt++;
      chk($sformatf("wd edge%0d", k), mem_timeout, (k >= WAIT_MAX) ? 1 : 0);
    end
    mem_req = 1'b0;
    repeat (3) step();
    chk("wd sticky", mem_timeout, 1);
    chk("wd stall_cnt", stall_cnt, exp_cnt);

    // Reset mid-WAIT clears asynchronously; the wait count restarts from zero.
    mem_req = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst timeout", mem_timeout, 0);
    chk("async rst stall_cnt", stall_cnt, 0);
    chk("async rst freeze", freeze, 1);
    exp_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= WAIT_MAX; k++) begin
      step();
      exp_cnt++;
      chk($sformatf("post rst wd%0d", k), mem_timeout, (k == WAIT_MAX) ? 1 : 0);
    end
    chk("post rst stall_cnt", stall_cnt, exp_cnt);

    // Long freeze saturates the stall counter.
    repeat (65534 - exp_cnt) step();
    chk("sat FFFE", stall_cnt, 16'hFFFE);
    step();
    chk("sat FFFF", stall_cnt, 16'hFFFF);
    repeat (4500) step();
    chk("sat hold", stall_cnt, 16'hFFFF);
    chk("sat timeout sticky", mem_timeout, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the ARM pipeline. Sits beside the EXE stage and generalises operand forwarding to NUM_SRC source operands and FWD_DEPTH downstream write-back stages, qualified by per-source valid bits. It adds sequential hazard handling: load-use stall/bubble generation, whole-pipeline freeze while data memory is busy, a memory-wait watchdog, and a saturating stall-cycle counter.

## Interface
- REG_AW, 4, register address width.
- NUM_SRC, 3, source operands per instruction (Rn, Rm, Rs).
- FWD_DEPTH, 2, forwardable stages downstream of EXE; stage 1 = MEM, stage FWD_DEPTH = WB.
- WAIT_MAX, 64, memory-wait cycles before the watchdog trips; minimum 1.
- SELW is derived, not settable: $clog2(FWD_DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- exe_src  in  NUM_SRC*REG_AW  source addresses of the EXE instruction; source i is at [i*REG_AW +: REG_AW].
- exe_src_vld  in  NUM_SRC  per-source used flag.
- id_src  in  NUM_SRC*REG_AW  source addresses of the ID instruction.
- id_src_vld  in  NUM_SRC  per-source used flag.
- exe_wb_en, exe_mem_r_en  in  1 each  EXE instruction writes a register / is a load.
- exe_dest  in  REG_AW  EXE destination.
- stg_wb_en  in  FWD_DEPTH  write enable of stages 1..FWD_DEPTH; bit k-1 is stage k.
- stg_dest  in  FWD_DEPTH*REG_AW  destinations; stage k is at [(k-1)*REG_AW +: REG_AW].
- flush  in  1  branch taken; the ID instruction is squashed.
- mem_req, mem_ready  in  1 each  data-memory access in MEM / access complete.
- fwd_sel  out  NUM_SRC*SELW  per-source mux select; 0 = register file, k = stage k.
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_id_exe  out  1  load a NOP into ID/EXE.
- freeze  out  1  hold every pipeline register.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Forwarding is combinational. For each source i: if exe_src_vld[i]=0, then fwd_sel=0. Otherwise fwd_sel is the smallest k with stg_wb_en[k-1] and stg_dest(k)==exe_src(i). The nearest stage wins. If no stage matches, fwd_sel=0.
- Load-use hazard (lu):
  - Condition: exe_mem_r_en & exe_wb_en & some i with id_src_vld[i] & id_src(i)==exe_dest.
  - lu is suppressed when flush=1.
- freeze = mem_req & ~mem_ready.
- Stall priority:
  - freeze=1: stall_if_id=1, bubble_id_exe=0.
  - Otherwise, lu=1: stall_if_id=1, bubble_id_exe=1.
  - Otherwise both are 0.
- FSM states:
  - RUN: go to WAIT when freeze=1.
  - WAIT: go to RUN when mem_ready=1 or mem_req=0.
  - wait_cnt clears in RUN and increments in WAIT, saturating at WAIT_MAX.
  - mem_timeout sets when in WAIT with wait_cnt==WAIT_MAX-1 and freeze still 1. It is cleared only by reset.
- stall_cnt increments on every clock where stall_if_id=1 and saturates at 16'hFFFF.
- Reset values: FSM=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0. Combinational outputs follow their inputs even during reset.
- Reset asserted mid-WAIT returns the FSM to RUN immediately; the counters clear.

## Timing
- fwd_sel, stall_if_id, bubble_id_exe and freeze: zero latency, same cycle as their inputs.
- The load-use stall lasts exactly one cycle: the bubble reaches EXE on the next edge, which clears exe_mem_r_en.
- mem_timeout is visible on the edge that completes WAIT_MAX consecutive frozen cycles.
- stall_cnt reflects the current cycle's stall on the following edge.
- Simultaneous lu and freeze: freeze wins. lu is re-evaluated once the freeze is released.
- Simultaneous lu and flush: no stall, no bubble.

## Configuration
- FWD_HAZARD_FORWARDING_EN defined: behaviour as described above.
- FWD_HAZARD_FORWARDING_EN undefined:
  - fwd_sel is tied to 0.
  - lu is replaced by a full RAW check. A stall plus bubble is generated when any valid id_src matches exe_dest (with exe_wb_en) or stg_dest(k) (with stg_wb_en) for k=1..FWD_DEPTH-1.
  - WB is excluded from the check: the register file writes before it reads.
  - Freeze, the watchdog and stall_cnt are unchanged.

## Test plan
- Nearest stage wins: exe_src(0)=3, vld=1; stage 1 and stage 2 both write r3 -> fwd_sel[0]=1. Clear stg_wb_en[0] -> fwd_sel[0]=2. Clear exe_src_vld[0] -> fwd_sel[0]=0.
- Load-use stall: load to r5 in EXE, id_src(1)=5 valid -> stall_if_id=1 and bubble_id_exe=1 for one cycle; stall_cnt goes 0->1. Repeat with flush=1 -> no stall, no bubble.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, with lu also true -> freeze=1, stall_if_id=1, bubble_id_exe=0 throughout. mem_ready=1 -> RUN, then a one-cycle lu bubble.
- Watchdog: WAIT_MAX=8, freeze held for 10 cycles -> mem_timeout rises after the 8th frozen cycle and stays 1 after release, until rst_n=0.
- Counter and reset: hold the stall for 70000 cycles -> stall_cnt=16'hFFFF. Assert rst_n=0 mid-WAIT -> FSM=RUN, stall_cnt=0, mem_timeout=0 asynchronously.
- Macro undefined: stage 1 writes r2 and id_src(0)=2 -> stall plus bubble, fwd_sel=0. A match on stage 2 (WB) only -> no stall.
